// File: rtl/ppm_frame_tx_if.sv
// Packet handshake between the holding register and the frame transmitter.
// Carries pkt_in/pkt_valid from the source and pkt_ready back from the sink.
interface ppm_frame_tx_if #(
  parameter int PKT_WIDTH = 32
);
  logic [PKT_WIDTH-1:0] pkt_in;
  logic                 pkt_valid;
  logic                 pkt_ready;

  modport master (
    output pkt_in,
    output pkt_valid,
    input  pkt_ready
  );

  modport slave (
    input  pkt_in,
    input  pkt_valid,
    output pkt_ready
  );
endinterface

// File: rtl/ppm_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB-first, then a quiet gap.
// Ports: clk, rst_n, bus (slave: pkt_in/pkt_valid/pkt_ready), tx_out, tx_active, done.
module ppm_frame_tx #(
  parameter int PKT_WIDTH   = 32,
  parameter int CYC_PER_BIT = 8,
  parameter int PRE_WIDTH   = 8,
  parameter logic [PRE_WIDTH-1:0] PREAMBLE = PRE_WIDTH'(8'hA5),
  parameter int GAP_BITS    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ppm_frame_tx_if.slave  bus,
  output logic           tx_out,
  output logic           tx_active,
  output logic           done
);

  localparam int MAXB = (PRE_WIDTH > PKT_WIDTH)
                      ? ((PRE_WIDTH > GAP_BITS) ? PRE_WIDTH : GAP_BITS)
                      : ((PKT_WIDTH > GAP_BITS) ? PKT_WIDTH : GAP_BITS);
  localparam int CW = $clog2(CYC_PER_BIT) + 1;
  localparam int BW = $clog2(MAXB) + 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_BIT - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(PRE_WIDTH - 1);
  localparam logic [BW-1:0] PKT_LAST = BW'(PKT_WIDTH - 1);
  localparam logic [BW-1:0] GAP_LAST =
    BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;
  logic [PKT_WIDTH-1:0] sr;
  logic [PRE_WIDTH-1:0] pre_sh;
  logic                 bnd;

  assign bus.pkt_ready = (state == IDLE);
  assign bnd    = (cnt == CYC_LAST);
  // next preamble bit sits at the top after shifting by bits already sent
  assign pre_sh = PREAMBLE << (bidx + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sr        <= '0;
      tx_out    <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        cnt <= bnd ? '0 : cnt + 1'b1;
      unique case (1'b1)
        (state == IDLE): begin
          tx_out <= 1'b0;
          if (bus.pkt_valid) begin
            sr        <= bus.pkt_in;
            bidx      <= '0;
            cnt       <= '0;
            state     <= PRE;
            tx_active <= 1'b1;
            tx_out    <= PREAMBLE[PRE_WIDTH-1];
          end
        end
        (state == PRE): begin
          if (bnd) begin
            if (bidx == PRE_LAST) begin
              state  <= DATA;
              bidx   <= '0;
              tx_out <= sr[PKT_WIDTH-1];
              sr     <= sr << 1;
            end else begin
              bidx   <= bidx + 1'b1;
              tx_out <= pre_sh[PRE_WIDTH-1];
            end
          end
        end
        (state == DATA): begin
          if (bnd) begin
            if (bidx == PKT_LAST) begin
              bidx   <= '0;
              tx_out <= 1'b0;
              if (GAP_BITS == 0) begin
                state     <= IDLE;
                tx_active <= 1'b0;
                done      <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              bidx   <= bidx + 1'b1;
              tx_out <= sr[PKT_WIDTH-1];
              sr     <= sr << 1;
            end
          end
        end
        (state == GAP): begin
          tx_out <= 1'b0;
          if (bnd) begin
            if (bidx == GAP_LAST) begin
              state     <= IDLE;
              bidx      <= '0;
              tx_active <= 1'b0;
              done      <= 1'b1;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_frame_tx.sv
// Directed bench for ppm_frame_tx: two builds (4 cyc/bit with gap, 1 cyc/bit no gap).
// Observes {tx_out, tx_active, done, pkt_ready} per cycle against hand-built streams.
module tb_ppm_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppm_frame_tx_if #(.PKT_WIDTH(8)) bus_a ();
  ppm_frame_tx_if #(.PKT_WIDTH(8)) bus_b ();

  logic tx_a, act_a, done_a;
  logic tx_b, act_b, done_b;

  ppm_frame_tx #(
    .PKT_WIDTH(8), .CYC_PER_BIT(4), .PRE_WIDTH(4),
    .PREAMBLE(4'b1010), .GAP_BITS(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .tx_out(tx_a), .tx_active(act_a), .done(done_a)
  );

  ppm_frame_tx #(
    .PKT_WIDTH(8), .CYC_PER_BIT(1), .PRE_WIDTH(4),
    .PREAMBLE(4'b1010), .GAP_BITS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
    .tx_out(tx_b), .tx_active(act_b), .done(done_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs(input int sel);
    if (sel == 0)
      return {tx_a, act_a, done_a, bus_a.pkt_ready};
    return {tx_b, act_b, done_b, bus_b.pkt_ready};
  endfunction

  task automatic set_pkt(input int sel, input logic v,
                         input logic [7:0] d);
    if (sel == 0) begin
      bus_a.pkt_valid = v;
      bus_a.pkt_in    = d;
    end else begin
      bus_b.pkt_valid = v;
      bus_b.pkt_in    = d;
    end
  endtask

  // Caller has a packet offered at a negedge; the next posedge accepts it.
  // Checks every frame cycle and the done cycle. keep=1 leaves valid high
  // and swaps pkt_in to nxt right after accept.
  task automatic frame(input string tag, input int sel,
                       input logic [7:0] pay, input int cpb,
                       input int gap, input bit keep,
                       input logic [7:0] nxt);
    logic [13:0] s;
    int nbits, total, b;
    logic [3:0] exp;
    s = {4'b1010, pay, 2'b00};
    nbits = 12 + gap;
    total = nbits * cpb;
    @(posedge clk);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c <= total) begin
        b = (c - 1) / cpb;
        exp = {s[13-b], 1'b1, 1'b0, 1'b0};
      end else begin
        exp = 4'b0011;
      end
      check($sformatf("%s c%0d", tag, c), 32'(obs(sel)), 32'(exp));
      if (c == 1) begin
        if (keep) set_pkt(sel, 1'b1, nxt);
        else      set_pkt(sel, 1'b0, 8'h00);
      end
    end
  endtask

  initial begin
    set_pkt(0, 1'b0, 8'h00);
    set_pkt(1, 1'b0, 8'h00);
    #2;
    check("rst_a", 32'(obs(0)), 32'h1);
    check("rst_b", 32'(obs(1)), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle hold
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_a %0d", i), 32'(obs(0)), 32'h1);
      check($sformatf("idle_b %0d", i), 32'(obs(1)), 32'h1);
    end

    // 2: single frame C3
    set_pkt(0, 1'b1, 8'hC3);
    frame("f_c3", 0, 8'hC3, 4, 2, 1'b0, 8'h00);

    // 3: back-to-back, payload change mid-frame ignored
    repeat (3) @(negedge clk);
    set_pkt(0, 1'b1, 8'hFF);
    frame("f_ff", 0, 8'hFF, 4, 2, 1'b1, 8'h01);
    frame("f_01", 0, 8'h01, 4, 2, 1'b0, 8'h00);

    // 4: async reset during DATA bit 3 (0x3C bit 3 is a 1)
    @(negedge clk);
    set_pkt(0, 1'b1, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    set_pkt(0, 1'b0, 8'h00);
    repeat (29) @(negedge clk);
    check("pre_rst", 32'(obs(0)), 32'hC);
    #2 rst_n = 1'b0;
    #1 check("in_rst", 32'(obs(0)), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst %0d", i), 32'(obs(0)), 32'h1);
    end
    set_pkt(0, 1'b1, 8'h5A);
    frame("f_5a", 0, 8'h5A, 4, 2, 1'b0, 8'h00);

    // 5: one cycle per bit, no gap
    @(negedge clk);
    set_pkt(1, 1'b1, 8'hA5);
    frame("f_b", 1, 8'hA5, 1, 0, 1'b0, 8'h00);
    @(negedge clk);
    check("b_idle", 32'(obs(1)), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
